// File: rtl/axi_lite_write_sched_if.sv
// AXI-Lite write-channel bundle (AW, W, B) shared between the write scheduler
// and the interconnect.
//   master : scheduler side, drives aw_addr/aw_valid, w_data/w_strb/w_valid, b_ready
//   slave  : interconnect side, drives aw_ready, w_ready, b_resp/b_valid
interface axi_lite_write_sched_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic                    aw_valid;
   logic                    aw_ready;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    w_valid;
   logic                    w_ready;
   logic [1:0]              b_resp;
   logic                    b_valid;
   logic                    b_ready;

   modport master (
      output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
      input  aw_ready, w_ready, b_resp, b_valid
   );

   modport slave (
      input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
      output aw_ready, w_ready, b_resp, b_valid
   );
endinterface

// File: rtl/axi_lite_write_sched.sv
// Shares one AXI-Lite write port between NREQ requesters, one transaction at a time.
// Requester 0 has fixed priority; requesters 1..NREQ-1 are served round-robin, and a
// starvation limiter forces a low-priority grant after STARVE_LIMIT back-to-back
// requester-0 grants while others pend.
//   clk, rst : clock and synchronous active-high reset
//   req_i    : per-requester request, held until ack_o
//   addr_i / data_i / strb_i : per-requester payload, slice i
//   ack_o    : one-cycle pulse, request i captured
//   done_o   : one-cycle pulse, B response for requester i received
//   err_o    : valid with done_o, set when b_resp != OKAY
//   axi      : AXI-Lite write master (AW, W, B)
module axi_lite_write_sched #(
   parameter int unsigned NREQ         = 4,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NREQ-1:0]                req_i,
   input  logic [NREQ*ADDR_WIDTH-1:0]     addr_i,
   input  logic [NREQ*DATA_WIDTH-1:0]     data_i,
   input  logic [NREQ*DATA_WIDTH/8-1:0]   strb_i,
   output logic [NREQ-1:0]                ack_o,
   output logic [NREQ-1:0]                done_o,
   output logic                           err_o,
   axi_lite_write_sched_if.master         axi
);
   localparam int unsigned PtrW = $clog2(NREQ);
   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned StrbW = DATA_WIDTH / 8;

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e          state_q;
   logic [PtrW-1:0] rr_q;
   logic [PtrW-1:0] owner_q;
   logic [CntW-1:0] starve_q;

   logic            any_lo;
   logic            force_lo;
   logic            grant0;
   logic            lo_found;
   logic [PtrW-1:0] lo_idx;
   logic [PtrW-1:0] winner;
   logic [PtrW-1:0] rr_next;
   int unsigned     cand;
   logic            aw_ok;
   logic            w_ok;

   // Winner selection for the current IDLE cycle.
   always_comb begin
      any_lo   = |req_i[NREQ-1:1];
      force_lo = (starve_q == CntW'(STARVE_LIMIT)) && any_lo;
      grant0   = req_i[0] && !force_lo;
      lo_found = 1'b0;
      lo_idx   = '0;
      cand     = 0;
      // Search starts at rr_q and wraps inside 1..NREQ-1, never reaching 0.
      for (int j = 0; j < int'(NREQ) - 1; j++) begin
         cand = (int'(rr_q) + j - 1) % (NREQ - 1) + 1;
         if (!lo_found && req_i[cand]) begin
            lo_found = 1'b1;
            lo_idx   = PtrW'(cand);
         end
      end
      winner  = grant0 ? '0 : lo_idx;
      rr_next = (lo_idx == PtrW'(NREQ - 1)) ? PtrW'(1) : lo_idx + PtrW'(1);
      // A channel counts as done once its valid has dropped or handshakes now.
      aw_ok   = !axi.aw_valid || axi.aw_ready;
      w_ok    = !axi.w_valid || axi.w_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         rr_q         <= PtrW'(1);
         owner_q      <= '0;
         starve_q     <= '0;
         ack_o        <= '0;
         done_o       <= '0;
         err_o        <= 1'b0;
         axi.aw_addr  <= '0;
         axi.aw_valid <= 1'b0;
         axi.w_data   <= '0;
         axi.w_strb   <= '0;
         axi.w_valid  <= 1'b0;
         axi.b_ready  <= 1'b0;
      end else begin
         ack_o  <= '0;
         done_o <= '0;
         err_o  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (!any_lo) begin
                  starve_q <= '0;
               end
               if (|req_i) begin
                  if (grant0) begin
                     if (any_lo && (starve_q != CntW'(STARVE_LIMIT))) begin
                        starve_q <= starve_q + CntW'(1);
                     end
                  end else begin
                     rr_q     <= rr_next;
                     starve_q <= '0;
                  end
                  owner_q        <= winner;
                  ack_o[winner]  <= 1'b1;
                  axi.aw_addr    <= addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                  axi.w_data     <= data_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                  axi.w_strb     <= strb_i[int'(winner)*StrbW +: StrbW];
                  axi.aw_valid   <= 1'b1;
                  axi.w_valid    <= 1'b1;
                  state_q        <= StIssue;
               end
            end
            StIssue: begin
               if (axi.aw_valid && axi.aw_ready) begin
                  axi.aw_valid <= 1'b0;
               end
               if (axi.w_valid && axi.w_ready) begin
                  axi.w_valid <= 1'b0;
               end
               if (aw_ok && w_ok) begin
                  axi.b_ready <= 1'b1;
                  state_q     <= StResp;
               end
            end
            StResp: begin
               if (axi.b_valid && axi.b_ready) begin
                  done_o[owner_q] <= 1'b1;
                  err_o           <= (axi.b_resp != 2'b00);
                  axi.b_ready     <= 1'b0;
                  state_q         <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_write_sched.sv
module tb_axi_lite_write_sched;
   localparam int unsigned NREQ = 4;
   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_i;
   logic [NREQ*AW-1:0]   addr_i;
   logic [NREQ*DW-1:0]   data_i;
   logic [NREQ*DW/8-1:0] strb_i;
   logic [NREQ-1:0]      ack_o;
   logic [NREQ-1:0]      done_o;
   logic                 err_o;

   int checks = 0;
   int fails  = 0;

   axi_lite_write_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axi_lite_write_sched #(
      .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(8)
   ) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .data_i(data_i),
      .strb_i(strb_i), .ack_o(ack_o), .done_o(done_o), .err_o(err_o), .axi(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      int r = -1;
      for (int i = 0; i < int'(NREQ); i++) if (v[i]) r = i;
      return r;
   endfunction

   // One transaction with the slave side already set up by the caller.
   task automatic run_txn(input logic drop, output int winner, output logic err_flag);
      logic got = 1'b0;
      logic [NREQ-1:0] exp_done;
      winner   = -1;
      err_flag = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (ack_o != '0) begin
            got    = 1'b1;
            winner = onehot_idx(ack_o);
            if (drop) req_i = '0;
         end
      end
      check_val("ack_seen", 64'(got), 64'd1);
      if (got) begin
         exp_done = '0;
         exp_done[winner] = 1'b1;
         got = 1'b0;
         for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (done_o != '0) begin
               got      = 1'b1;
               err_flag = err_o;
               check_val("done_owner", 64'(done_o), 64'(exp_done));
            end
         end
         check_val("done_seen", 64'(got), 64'd1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   int   w;
   logic e;
   int   exp_starve[10];
   int   exp_rr[4];

   initial begin
      rst          = 1'b1;
      req_i        = '0;
      addr_i       = '0;
      data_i       = '0;
      strb_i       = '0;
      bus.aw_ready = 1'b0;
      bus.w_ready  = 1'b0;
      bus.b_valid  = 1'b0;
      bus.b_resp   = 2'b00;
      do_reset();

      // Reset state
      check_val("rst_ack", 64'(ack_o), 64'd0);
      check_val("rst_done", 64'(done_o), 64'd0);
      check_val("rst_err", 64'(err_o), 64'd0);
      check_val("rst_awv", 64'(bus.aw_valid), 64'd0);
      check_val("rst_wv", 64'(bus.w_valid), 64'd0);
      check_val("rst_bready", 64'(bus.b_ready), 64'd0);
      check_val("rst_awaddr", 64'(bus.aw_addr), 64'd0);
      check_val("rst_wdata", 64'(bus.w_data), 64'd0);

      // Single write from requester 1
      addr_i[1*AW +: AW]     = 32'h1000_0040;
      data_i[1*DW +: DW]     = 32'hDEAD_BEEF;
      strb_i[1*DW/8 +: DW/8] = 4'hF;
      req_i        = 4'b0010;
      bus.aw_ready = 1'b1;
      bus.w_ready  = 1'b1;
      @(negedge clk);
      check_val("sw_ack", 64'(ack_o), 64'h2);
      check_val("sw_awv", 64'(bus.aw_valid), 64'd1);
      check_val("sw_wv", 64'(bus.w_valid), 64'd1);
      check_val("sw_awaddr", 64'(bus.aw_addr), 64'h1000_0040);
      check_val("sw_wdata", 64'(bus.w_data), 64'hDEAD_BEEF);
      check_val("sw_wstrb", 64'(bus.w_strb), 64'hF);
      check_val("sw_bready0", 64'(bus.b_ready), 64'd0);
      req_i = '0;
      @(negedge clk);
      check_val("sw_ack_pulse", 64'(ack_o), 64'd0);
      check_val("sw_awv_drop", 64'(bus.aw_valid), 64'd0);
      check_val("sw_wv_drop", 64'(bus.w_valid), 64'd0);
      check_val("sw_bready1", 64'(bus.b_ready), 64'd1);
      bus.b_valid = 1'b1;
      bus.b_resp  = 2'b00;
      @(negedge clk);
      check_val("sw_done", 64'(done_o), 64'h2);
      check_val("sw_err", 64'(err_o), 64'd0);
      check_val("sw_bready_drop", 64'(bus.b_ready), 64'd0);
      bus.b_valid = 1'b0;
      @(negedge clk);
      check_val("sw_done_pulse", 64'(done_o), 64'd0);

      // Skewed handshakes: AW accepted at once, W stalled, early b_valid present
      addr_i[2*AW +: AW]     = 32'h2000_0008;
      data_i[2*DW +: DW]     = 32'h1234_5678;
      strb_i[2*DW/8 +: DW/8] = 4'h3;
      req_i        = 4'b0100;
      bus.aw_ready = 1'b1;
      bus.w_ready  = 1'b0;
      bus.b_valid  = 1'b1;
      @(negedge clk);
      check_val("sk_ack", 64'(ack_o), 64'h4);
      req_i = '0;
      @(negedge clk);
      check_val("sk_awv_drop", 64'(bus.aw_valid), 64'd0);
      check_val("sk_wv_held", 64'(bus.w_valid), 64'd1);
      check_val("sk_bready_lo", 64'(bus.b_ready), 64'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_val("sk_wv_stall", 64'(bus.w_valid), 64'd1);
         check_val("sk_wdata_stable", 64'(bus.w_data), 64'h1234_5678);
         check_val("sk_wstrb_stable", 64'(bus.w_strb), 64'h3);
         check_val("sk_no_early_b", 64'(done_o), 64'd0);
         check_val("sk_bready_stall", 64'(bus.b_ready), 64'd0);
      end
      bus.w_ready = 1'b1;
      @(negedge clk);
      check_val("sk_wv_drop", 64'(bus.w_valid), 64'd0);
      check_val("sk_bready_hi", 64'(bus.b_ready), 64'd1);
      check_val("sk_done_wait", 64'(done_o), 64'd0);
      @(negedge clk);
      check_val("sk_done", 64'(done_o), 64'h4);
      check_val("sk_err", 64'(err_o), 64'd0);
      bus.b_valid = 1'b0;
      @(negedge clk);

      // Starvation: 0 and 2 held -> eight grants to 0, then 2, then 0
      exp_starve = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 0};
      bus.b_valid = 1'b1;
      req_i = 4'b0101;
      for (int n = 0; n < 10; n++) begin
         run_txn(1'b0, w, e);
         check_val($sformatf("starve_gnt%0d", n), 64'(w), 64'(exp_starve[n]));
      end
      req_i = '0;
      @(negedge clk);

      // Error response from requester 3, then a normal grant
      req_i       = 4'b1000;
      bus.b_resp  = 2'b10;
      run_txn(1'b1, w, e);
      check_val("err_gnt", 64'(w), 64'd3);
      check_val("err_flag", 64'(e), 64'd1);
      bus.b_resp = 2'b00;
      req_i      = 4'b0001;
      run_txn(1'b1, w, e);
      check_val("post_err_gnt", 64'(w), 64'd0);
      check_val("post_err_flag", 64'(e), 64'd0);
      @(negedge clk);

      // Reset while in ISSUE with aw_valid high
      bus.aw_ready = 1'b0;
      bus.w_ready  = 1'b0;
      bus.b_valid  = 1'b0;
      req_i        = 4'b0010;
      @(negedge clk);
      check_val("rm_awv_pre", 64'(bus.aw_valid), 64'd1);
      req_i = '0;
      rst   = 1'b1;
      @(negedge clk);
      check_val("rm_awv", 64'(bus.aw_valid), 64'd0);
      check_val("rm_wv", 64'(bus.w_valid), 64'd0);
      check_val("rm_bready", 64'(bus.b_ready), 64'd0);
      check_val("rm_ack", 64'(ack_o), 64'd0);
      check_val("rm_awaddr", 64'(bus.aw_addr), 64'd0);
      rst          = 1'b0;
      bus.aw_ready = 1'b1;
      bus.w_ready  = 1'b1;
      bus.b_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("rm_no_done", 64'(done_o), 64'd0);
      end
      req_i = 4'b0010;
      run_txn(1'b1, w, e);
      check_val("rm_fresh_gnt", 64'(w), 64'd1);
      check_val("rm_fresh_err", 64'(e), 64'd0);

      // Round-robin from reset: 1,2,3 held -> 1,2,3,1
      do_reset();
      exp_rr = '{1, 2, 3, 1};
      req_i  = 4'b1110;
      for (int n = 0; n < 4; n++) begin
         run_txn(1'b0, w, e);
         check_val($sformatf("rr_gnt%0d", n), 64'(w), 64'(exp_rr[n]));
      end
      req_i = '0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
